// File: rtl/nios2system_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios2system_pio_pkg
//  Description : Shared constants for the Nios II PIO blocks: Avalon word
//                addresses of the register map and edge-capture encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios2system_pio_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge type selection for the edge-capture register
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage : nios2system_pio_pkg
`default_nettype wire

// File: rtl/nios2system_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : nios2system_debounce_bit
//  Description : Single-line input conditioner: two-flop synchroniser followed
//                by a saturating-free stability counter. A new level is only
//                accepted after DEBOUNCE_CYCLES consecutive cycles of
//                disagreement with the current stable level (0 = bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2system_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic r_s1;
    logic r_s2;
    logic r_stable;

    // Two-flop synchroniser for the asynchronous input line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: follow the synchronised input one cycle later
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stable <= 1'b0;
                end else begin
                    r_stable <= r_s2;
                end
            end
        end else begin : g_filter
            localparam int              CW     = $clog2(DEBOUNCE_CYCLES) + 1;
            localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_count;

            // Count cycles of disagreement; accept the new level on the last one.
            // Any agreement restarts the count, so short glitches never pass.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_count  <= '0;
                    r_stable <= 1'b0;
                end else if (r_s2 == r_stable) begin
                    r_count  <= '0;
                end else if (r_count == C_LAST) begin
                    r_count  <= '0;
                    r_stable <= r_s2;
                end else begin
                    r_count  <= r_count + CW'(1);
                end
            end
        end
    endgenerate

    assign dout = r_stable;

endmodule : nios2system_debounce_bit
`default_nettype wire

// File: rtl/nios2system_key_in.sv
`default_nettype none
// ============================================================================
//  Module      : nios2system_key_in
//  Description : Avalon-MM slave input PIO. Debounces asynchronous key/switch
//                lines, captures edges into a W1C register, and raises a
//                level interrupt when an unmasked captured edge is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2system_key_in
    import nios2system_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic             w_wr_hit;
    logic             w_unused_ok;

    // One conditioner per input line
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            nios2system_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[i]),
                .dout  (w_stable[i])
            );
        end
    endgenerate

    // Delayed copy of the stable levels for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_stable;
        end
    end

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_falling
            assign w_edge = ~w_stable & r_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
            assign w_edge = w_stable ^ r_prev;
        end else begin : g_edge_rising
            assign w_edge = w_stable & ~r_prev;
        end
    endgenerate

    assign w_wr_hit = chipselect & ~write_n;
    assign w_clr    = (w_wr_hit && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr_hit && (address == ADDR_IRQMASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-1-to-clear, a new edge in the same cycle wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // Zero-latency read mux; reads have no side effects
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    readdata = 32'(w_stable);
                ADDR_DIR:     readdata = '0;
                ADDR_IRQMASK: readdata = 32'(r_irqmask);
                ADDR_EDGECAP: readdata = 32'(r_edgecap);
                default:      readdata = '0;
            endcase
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

    // Read strobe is unnecessary with zero-latency side-effect-free reads
    assign w_unused_ok = &{1'b0, read_n, writedata};

endmodule : nios2system_key_in
`default_nettype wire

// File: doc/nios2system_key_in.md
Name: nios2system_key_in

Overview:
- Avalon-MM slave input PIO; the read-side counterpart of the hex display output PIOs.
- Samples asynchronous push-button/switch lines, synchronises and debounces them, and captures edges.
- Presents data, interrupt mask and edge-capture registers to the Nios II data master.
- Drives a level IRQ into the system interconnect.

Parameters:
WIDTH, 4, number of input lines (1..32)
DEBOUNCE_CYCLES, 16, consecutive stable clk cycles needed before a new level is accepted; 0 = debounce bypassed
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  read data, zero read latency
irq  out  1  interrupt request, level, active-high

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All flops clear only on a clk edge where reset=1.
- Reset values:
  - sync stages, stable, prev = 0
  - debounce counters = 0
  - irqmask = 0, edgecapture = 0
  - irq = 0
- Reset mid-debounce discards any partial count.
- Synchroniser: 2-flop chain per bit, in_port -> s1 -> s2.
- Debounce (per bit, DEBOUNCE_CYCLES>0):
  - If s2 == stable, counter clears to 0.
  - Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1 and s2 still differs, stable <= s2 and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1 and it never wraps.
- Bypass (DEBOUNCE_CYCLES=0): stable <= s2 each cycle.
- Total latency from an in_port change to a stable change: 2 + DEBOUNCE_CYCLES cycles (bypass: 3 cycles).
- prev <= stable every cycle. Edge detect per bit:
  - rising = stable & ~prev
  - falling = ~stable & prev
  - any = rising | falling
  - The edge is visible in edgecapture the cycle after it is detected.
- Register map (word addresses):
  - 0 data, RO: readdata = zero-extended stable. Writes ignored.
  - 1 direction: not implemented, reads 0, writes ignored.
  - 2 irqmask, RW: on write, irqmask <= writedata[WIDTH-1:0].
  - 3 edgecapture, RW1C: writing 1 to a bit clears it.
- Edge capture update per bit: edgecapture <= (edgecapture & ~clr) | edge, where clr = write hit on address 3 & writedata[WIDTH-1:0].
- A new edge in the same cycle as a clear of that bit: the edge wins and the bit stays 1.
- Avalon access rules:
  - Write hit = chipselect & ~write_n.
  - readdata is combinational from address while chipselect=1, and 0 otherwise.
  - Reads have no side effects. Read latency 0, no waitrequest.
  - Bits above WIDTH read 0.
- irq = |(edgecapture & irqmask), driven from registers (combinational OR of flop outputs, no extra stage).
  - irq deasserts in the cycle after the clearing write.
  - irq deasserts when the mask is written to 0.
- Width rules: writedata[31:WIDTH] ignored on every register.

Decomposition:
- Shared package nios2system_pio_pkg:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings
- Sub-module nios2system_debounce_bit:
  - one instance per bit via generate
  - contains the sync chain, counter and stable flop
  - ports clk, reset, din, dout
- Edge capture, register file and Avalon decode stay in the top level.

Test Plan:
- Reset: assert reset for 2 cycles with in_port=4'hF. Required: readdata@0 == 0, irq=0 during reset, and all registers read 0 in the first cycle after release.
- Debounce accept: WIDTH=4, DEBOUNCE_CYCLES=16; in_port 0 -> 4'b0001 held. Required: data reads 0 for the first 17 cycles and 1 from cycle 18. edgecapture bit0=1 one cycle later (EDGE_TYPE=0).
- Glitch reject: pulse in_port[1] high for 10 cycles, then low. Required: data stays 0, edgecapture stays 0, irq stays 0.
- Interrupt path:
  - Write irqmask=4'b0001, then create a rising edge on bit0. Required: irq=1 the cycle edgecapture[0] sets.
  - Write 32'h1 to address 3. Required: edgecapture=0 and irq=0 on the next cycle.
  - Masked bit: an edge on bit2 with mask bit2=0 sets edgecapture[2] but irq stays 0.
- Simultaneous set/clear: time the write of 32'hF to address 3 to land in the cycle a new edge on bit3 is detected. Required: edgecapture reads 4'b1000 afterwards.
- Unused/out-of-range: write 32'hFFFF_FFFF to address 1 and to address 0. Required: address 1 reads 0 and the data register is unchanged. Read address 2 after writing 32'hFFFF_FFF5: result is 32'h0000_0005.
